game_render_sequencer: RTL and testbench

- Parametrised frame-render sequencer for the game view.
- Per frame it:
  - rolls random object positions when a new level starts,
  - draws the background,
  - walks every object slot of every object class (gold, stone, diamond, ... generalised to NUM_CLASSES),
  - draws the hook, then the score digits.
- It then either waits for the next frame tick or parks on game end.
- It owns the per-class slot counters itself, skips slots that are no longer alive, and has a per-draw watchdog so a hung drawer cannot stall the frame.

---
 rtl/game_render_sequencer_if.sv | 56 +++++
 rtl/game_render_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_game_render_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_render_sequencer_if.sv
// -----------------------------------------------------------------------------
// game_render_sequencer_if
// Bundles every control, status and drawer handshake signal of the frame-render
// sequencer. clk and resetn are not part of the bundle.
//   master : the sequencer (drives enables, pulses and status)
//   slave  : the game logic plus drawers (drives go/tick/end, counts, dones)
// Signals:
//   go, frame_tick, game_end          game control inputs to the sequencer
//   class_count, alive_mask           object population, sampled while selecting
//   enable_random                     one-cycle reroll of object positions
//   enable_draw_background / done     background drawer handshake
//   enable_draw_obj / draw_obj_done   per-class object drawer handshake
//   obj_index                         slot being drawn
//   enable_draw_hook / done           hook drawer handshake
//   enable_draw_num / done            score drawer handshake
//   resetn_objects, frame_done        end-of-frame pulses
//   draw_error                        sticky watchdog-expiry flag
// -----------------------------------------------------------------------------
interface game_render_sequencer_if #(
   parameter int NUM_CLASSES = 3,
   parameter int MAX_PER     = 4,
   parameter int IDX_W       = 3
);
   logic                           go;
   logic                           frame_tick;
   logic                           game_end;
   logic [NUM_CLASSES*IDX_W-1:0]   class_count;
   logic [NUM_CLASSES*MAX_PER-1:0] alive_mask;
   logic                           enable_random;
   logic                           enable_draw_background;
   logic                           draw_background_done;
   logic [NUM_CLASSES-1:0]         enable_draw_obj;
   logic [NUM_CLASSES-1:0]         draw_obj_done;
   logic [IDX_W-1:0]               obj_index;
   logic                           enable_draw_hook;
   logic                           draw_hook_done;
   logic                           enable_draw_num;
   logic                           draw_num_done;
   logic                           resetn_objects;
   logic                           frame_done;
   logic                           draw_error;

   modport master (
      input  go, frame_tick, game_end, class_count, alive_mask,
             draw_background_done, draw_obj_done, draw_hook_done, draw_num_done,
      output enable_random, enable_draw_background, enable_draw_obj, obj_index,
             enable_draw_hook, enable_draw_num, resetn_objects, frame_done, draw_error
   );

   modport slave (
      output go, frame_tick, game_end, class_count, alive_mask,
             draw_background_done, draw_obj_done, draw_hook_done, draw_num_done,
      input  enable_random, enable_draw_background, enable_draw_obj, obj_index,
             enable_draw_hook, enable_draw_num, resetn_objects, frame_done, draw_error
   );
endinterface

// File: rtl/game_render_sequencer.sv
// -----------------------------------------------------------------------------
// game_render_sequencer
// Per frame: reroll objects (only when a level starts), draw the background,
// walk every alive slot of every object class, draw the hook, draw the score,
// then wait for the next frame tick or park when the game has ended.
// Each drawer handshake is guarded by a watchdog; an expiry finishes the draw
// as if done had arrived and raises the sticky draw_error flag.
// Ports:
//   clk     system clock
//   resetn  asynchronous active-low reset
//   bus     game_render_sequencer_if.master (all control/handshake signals)
// All outputs are pure decodes of registered state and counters.
// -----------------------------------------------------------------------------
module game_render_sequencer #(
   parameter int          NUM_CLASSES = 3,
   parameter int          MAX_PER     = 4,
   parameter int          IDX_W       = 3,
   parameter logic [15:0] TIMEOUT     = 16'd50000
) (
   input  logic                    clk,
   input  logic                    resetn,
   game_render_sequencer_if.master bus
);
   localparam int                     CLS_W    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
   localparam logic [CLS_W-1:0]       LAST_CLS = CLS_W'(NUM_CLASSES - 1);
   localparam logic [CLS_W-1:0]       CLS_ZERO = {CLS_W{1'b0}};
   localparam logic [CLS_W-1:0]       CLS_ONE  = CLS_W'(1);
   localparam logic [IDX_W-1:0]       IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]       IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0]       MAX_IDX  = IDX_W'(MAX_PER);
   localparam logic [NUM_CLASSES-1:0] OH_LSB   = NUM_CLASSES'(1);

   typedef enum logic [3:0] {
      ST_GEN       = 4'd0,
      ST_BG        = 4'd1,
      ST_SEL       = 4'd2,
      ST_OBJ       = 4'd3,
      ST_HOOK      = 4'd4,
      ST_NUM       = 4'd5,
      ST_FRAME_END = 4'd6,
      ST_WAIT_TICK = 4'd7,
      ST_GAME_DONE = 4'd8
   } state_t;

   state_t                     state_r, state_s;
   logic [CLS_W-1:0]           cls_r, cls_s;
   logic [IDX_W-1:0]           idx_r, idx_s;
   logic [15:0]                wd_r, wd_s;
   logic                       draw_error_r, draw_error_s;
   // armed_r holds GEN for one cycle after reset so enable_random stays low in reset
   logic                       armed_r;
   logic                       draw_state_s, done_s, expire_s, hit_s;
   logic [IDX_W-1:0]           count_field_s, eff_count_s;
   logic [NUM_CLASSES*MAX_PER-1:0] alive_shift_s;
   logic                       alive_bit_s;

   // Decode of the slot currently under selection: clamped count and alive bit
   always_comb begin
      count_field_s = bus.class_count[cls_r*IDX_W +: IDX_W];
      eff_count_s   = (count_field_s > MAX_IDX) ? MAX_IDX : count_field_s;
      alive_shift_s = bus.alive_mask >> (cls_r*MAX_PER + idx_r);
      alive_bit_s   = alive_shift_s[0];
   end

   // Which states run a drawer handshake, and the done that state honours
   always_comb begin
      draw_state_s = 1'b0;
      done_s       = 1'b0;
      case (state_r)
         ST_BG:   begin draw_state_s = 1'b1; done_s = bus.draw_background_done; end
         ST_OBJ:  begin draw_state_s = 1'b1; done_s = bus.draw_obj_done[cls_r]; end
         ST_HOOK: begin draw_state_s = 1'b1; done_s = bus.draw_hook_done; end
         ST_NUM:  begin draw_state_s = 1'b1; done_s = bus.draw_num_done; end
         default: begin draw_state_s = 1'b0; done_s = 1'b0; end
      endcase
   end

   // Watchdog expiry on the last allowed cycle; TIMEOUT of zero disables it
   assign expire_s = (TIMEOUT != 16'd0) && (wd_r == (TIMEOUT - 16'd1));
   assign hit_s    = draw_state_s && (done_s || expire_s);

   // Next-state, counter and error-flag logic
   always_comb begin
      state_s      = state_r;
      cls_s        = cls_r;
      idx_s        = idx_r;
      wd_s         = 16'd0;
      draw_error_s = draw_error_r;

      // go clears the flag from any state; done wins over a simultaneous expiry
      if (bus.go) begin
         draw_error_s = 1'b0;
      end else if (draw_state_s && !done_s && expire_s) begin
         draw_error_s = 1'b1;
      end else begin
         draw_error_s = draw_error_r;
      end

      // wd is zero on entry to every handshake state because every exit clears it
      if (draw_state_s && !hit_s) begin
         wd_s = wd_r + 16'd1;
      end else begin
         wd_s = 16'd0;
      end

      case (state_r)
         ST_GEN: begin
            if (armed_r) state_s = ST_BG;
            else         state_s = ST_GEN;
         end
         ST_BG: begin
            if (hit_s) begin
               state_s = ST_SEL;
               cls_s   = CLS_ZERO;
               idx_s   = IDX_ZERO;
            end else begin
               state_s = ST_BG;
            end
         end
         ST_SEL: begin
            if (idx_r < eff_count_s) begin
               if (alive_bit_s) begin
                  state_s = ST_OBJ;
               end else begin
                  idx_s = idx_r + IDX_ONE;
               end
            end else begin
               idx_s = IDX_ZERO;
               if (cls_r == LAST_CLS) begin
                  state_s = ST_HOOK;
                  cls_s   = CLS_ZERO;
               end else begin
                  cls_s = cls_r + CLS_ONE;
               end
            end
         end
         ST_OBJ: begin
            if (hit_s) begin
               state_s = ST_SEL;
               idx_s   = idx_r + IDX_ONE;
            end else begin
               state_s = ST_OBJ;
            end
         end
         ST_HOOK: begin
            if (hit_s) state_s = ST_NUM;
            else       state_s = ST_HOOK;
         end
         ST_NUM: begin
            if (hit_s) state_s = ST_FRAME_END;
            else       state_s = ST_NUM;
         end
         ST_FRAME_END: begin
            if (bus.game_end) state_s = ST_GAME_DONE;
            else              state_s = ST_WAIT_TICK;
         end
         ST_WAIT_TICK: begin
            if (bus.frame_tick) state_s = ST_BG;
            else                state_s = ST_WAIT_TICK;
         end
         ST_GAME_DONE: begin
            if (bus.go) state_s = ST_GEN;
            else        state_s = ST_GAME_DONE;
         end
         default: begin
            state_s = ST_GEN;
            cls_s   = CLS_ZERO;
            idx_s   = IDX_ZERO;
         end
      endcase
   end

   // State, counter and flag registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r      <= ST_GEN;
         cls_r        <= CLS_ZERO;
         idx_r        <= IDX_ZERO;
         wd_r         <= 16'd0;
         draw_error_r <= 1'b0;
         armed_r      <= 1'b0;
      end else begin
         state_r      <= state_s;
         cls_r        <= cls_s;
         idx_r        <= idx_s;
         wd_r         <= wd_s;
         draw_error_r <= draw_error_s;
         armed_r      <= 1'b1;
      end
   end

   assign bus.enable_random          = (state_r == ST_GEN) && armed_r;
   assign bus.enable_draw_background = (state_r == ST_BG);
   assign bus.enable_draw_obj        = (state_r == ST_OBJ) ? (OH_LSB << cls_r) : {NUM_CLASSES{1'b0}};
   assign bus.obj_index              = (state_r == ST_OBJ) ? idx_r : IDX_ZERO;
   assign bus.enable_draw_hook       = (state_r == ST_HOOK);
   assign bus.enable_draw_num        = (state_r == ST_NUM);
   assign bus.resetn_objects         = (state_r != ST_FRAME_END);
   assign bus.frame_done             = (state_r == ST_FRAME_END);
   assign bus.draw_error             = draw_error_r;
endmodule

// File: tb/tb_game_render_sequencer.sv
module tb_game_render_sequencer;
   localparam int NC = 3;
   localparam int MP = 4;
   localparam int IW = 3;

   typedef int exp_t [12];

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   game_render_sequencer_if #(.NUM_CLASSES(NC), .MAX_PER(MP), .IDX_W(IW)) bus ();

   game_render_sequencer #(
      .NUM_CLASSES(NC), .MAX_PER(MP), .IDX_W(IW), .TIMEOUT(16'd8)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // drawer behaviour knobs, written only by the stimulus block
   int         lat2  = 1;       // negedges class-2 drawer waits before done
   logic [2:0] stray = 3'b000;  // done bits forced high regardless of request

   // Drawer models: answer done on the negedge after a request is seen
   int held2 = 0;
   always @(negedge clk) begin
      if (bus.enable_draw_obj[2]) held2 = held2 + 1;
      else                        held2 = 0;
      bus.draw_background_done = bus.enable_draw_background;
      bus.draw_hook_done       = bus.enable_draw_hook;
      bus.draw_num_done        = bus.enable_draw_num;
      bus.draw_obj_done[0]     = bus.enable_draw_obj[0] | stray[0];
      bus.draw_obj_done[1]     = bus.enable_draw_obj[1] | stray[1];
      bus.draw_obj_done[2]     = (bus.enable_draw_obj[2] && (held2 >= lat2)) | stray[2];
   end

   // Activity monitor: counts pulses and logs each new object draw as cls*16+idx
   int   cyc = 0, rand_cnt = 0, bg_cnt = 0, hook_cnt = 0, num_cnt = 0, fd_cnt = 0;
   int   en2_cyc = 0, onehot_err = 0;
   int   obj_log[$];
   int   obj_t[$];
   logic prev_bg = 1'b0, prev_hook = 1'b0, prev_num = 1'b0;
   logic [NC-1:0] prev_obj = '0;
   logic [IW-1:0] prev_idx = '0;
   always @(negedge clk) begin
      int cc;
      cyc = cyc + 1;
      if (bus.enable_random) rand_cnt = rand_cnt + 1;
      if (bus.enable_draw_background && !prev_bg) bg_cnt = bg_cnt + 1;
      if (bus.enable_draw_hook && !prev_hook) hook_cnt = hook_cnt + 1;
      if (bus.enable_draw_num && !prev_num) num_cnt = num_cnt + 1;
      if (bus.frame_done) fd_cnt = fd_cnt + 1;
      if (bus.enable_draw_obj[2]) en2_cyc = en2_cyc + 1;
      if (!$onehot0(bus.enable_draw_obj)) onehot_err = onehot_err + 1;
      if (bus.enable_draw_obj != '0 &&
          (bus.enable_draw_obj != prev_obj || bus.obj_index != prev_idx)) begin
         cc = 0;
         for (int c = 0; c < NC; c++) if (bus.enable_draw_obj[c]) cc = c;
         obj_log.push_back(cc * 16 + int'(bus.obj_index));
         obj_t.push_back(cyc);
      end
      prev_bg   = bus.enable_draw_background;
      prev_hook = bus.enable_draw_hook;
      prev_num  = bus.enable_draw_num;
      prev_obj  = bus.enable_draw_obj;
      prev_idx  = bus.obj_index;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_fd(input int budget, output int n);
      n = 0;
      while (!bus.frame_done && n < budget) begin
         step();
         n++;
      end
      chk("frame_done_reached", bus.frame_done, 1);
   endtask

   task automatic chk_objs(input string tag, input int base, input int n, input exp_t e);
      chk($sformatf("%s_count", tag), obj_log.size() - base, n);
      for (int k = 0; k < n; k++)
         chk($sformatf("%s_obj%0d", tag, k),
             (base + k < obj_log.size()) ? obj_log[base + k] : -1, e[k]);
   endtask

   task automatic tick_pulse();
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
   endtask

   initial begin
      int n, base, snap, snap2;
      bool_found: begin end
      resetn          = 1'b0;
      bus.go          = 1'b0;
      bus.frame_tick  = 1'b0;
      bus.game_end    = 1'b0;
      bus.class_count = {3'd1, 3'd3, 3'd2};
      bus.class_count = {3'd2, 3'd3, 3'd1};
      bus.alive_mask  = 12'hFFF;
      step(); step(); step();

      // reset state
      chk("rst_random", bus.enable_random, 0);
      chk("rst_bg", bus.enable_draw_background, 0);
      chk("rst_obj", bus.enable_draw_obj, 0);
      chk("rst_idx", bus.obj_index, 0);
      chk("rst_hook_num", {bus.enable_draw_hook, bus.enable_draw_num}, 0);
      chk("rst_resetn_objects", bus.resetn_objects, 1);
      chk("rst_frame_done", bus.frame_done, 0);
      chk("rst_error", bus.draw_error, 0);

      // first frame after reset release
      resetn = 1'b1;
      step();
      chk("f1_random_pulse", bus.enable_random, 1);
      step();
      chk("f1_random_low", bus.enable_random, 0);
      chk("f1_bg", bus.enable_draw_background, 1);
      wait_fd(60, n);
      chk("f1_len", n, 18);
      chk("f1_resetn_objects", bus.resetn_objects, 0);
      chk("f1_counts", {8'(rand_cnt), 8'(bg_cnt), 8'(hook_cnt), 8'(num_cnt)}, 32'h01010101);
      chk_objs("f1", 0, 6, '{0, 16, 17, 18, 32, 33, 0, 0, 0, 0, 0, 0});
      step();
      chk("f1_fd_low", bus.frame_done, 0);
      chk("f1_ro_high", bus.resetn_objects, 1);
      step(); step();
      chk("f1_waiting", {bus.enable_draw_background, 8'(fd_cnt)}, 1);

      // class1 slot1 not alive
      bus.alive_mask = 12'hFDF;
      base = obj_log.size();
      tick_pulse();
      chk("f2_bg", bus.enable_draw_background, 1);
      wait_fd(60, n);
      chk("f2_len", n, 17);
      chk_objs("f2", base, 5, '{0, 16, 18, 32, 33, 0, 0, 0, 0, 0, 0, 0});
      chk("f2_sel_dwell", obj_t[base + 2] - obj_t[base + 1], 3);
      chk("f2_no_reroll", rand_cnt, 1);

      // class0 count above MAX_PER is clamped
      step();
      bus.alive_mask  = 12'hFFF;
      bus.class_count = {3'd2, 3'd3, 3'd7};
      base = obj_log.size();
      tick_pulse();
      wait_fd(60, n);
      chk("f3_len", n, 24);
      chk_objs("f3", base, 9, '{0, 1, 2, 3, 16, 17, 18, 32, 33, 0, 0, 0});
      // frame_tick during FRAME_END is not queued
      snap = bg_cnt;
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step(); step();
      chk("tick_not_queued", {bus.enable_draw_background, 8'(bg_cnt - snap)}, 0);

      // class2 drawer hangs, stray dones on other classes, game ends
      bus.class_count = {3'd1, 3'd1, 3'd1};
      lat2 = 255;
      stray = 3'b011;
      bus.game_end = 1'b1;
      snap = en2_cyc;
      base = obj_log.size();
      tick_pulse();
      wait_fd(80, n);
      chk("f4_len", n, 19);
      chk("f4_en2_cycles", en2_cyc - snap, 8);
      chk("f4_error", bus.draw_error, 1);
      chk_objs("f4", base, 3, '{0, 16, 32, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      step();
      stray = 3'b000;
      lat2 = 8;
      bus.game_end = 1'b0;
      snap = fd_cnt;
      snap2 = bg_cnt;
      bus.frame_tick = 1'b1;
      step(); step();
      bus.frame_tick = 1'b0;
      step();
      chk("gd_tick_ignored", {8'(bg_cnt - snap2), 8'(fd_cnt - snap), 7'd0, bus.enable_random}, 0);
      chk("gd_error_sticky", bus.draw_error, 1);
      snap = rand_cnt;
      bus.go = 1'b1;
      step();
      bus.go = 1'b0;
      chk("gd_go_random", bus.enable_random, 1);
      chk("gd_go_clears", bus.draw_error, 0);
      step();
      chk("gd_bg", {bus.enable_draw_background, 8'(rand_cnt - snap)}, 9'h101);

      // done arriving on the watchdog's last cycle counts as done
      snap = en2_cyc;
      wait_fd(80, n);
      chk("f5_len", n, 19);
      chk("f5_en2_cycles", en2_cyc - snap, 8);
      chk("f5_no_error", bus.draw_error, 0);

      // go outside GAME_DONE only clears draw_error
      step();
      lat2 = 255;
      tick_pulse();
      wait_fd(80, n);
      chk("f6_error", bus.draw_error, 1);
      step();
      bus.go = 1'b1;
      step();
      bus.go = 1'b0;
      chk("wt_go_clears", bus.draw_error, 0);
      chk("wt_go_no_random", bus.enable_random, 0);
      step();
      chk("wt_go_no_bg", bus.enable_draw_background, 0);
      lat2 = 1;
      snap = rand_cnt;
      tick_pulse();
      chk("wt_tick_bg", bus.enable_draw_background, 1);
      chk("wt_tick_no_random", rand_cnt - snap, 0);
      wait_fd(60, n);
      chk("f7_len", n, 12);

      // reset in the middle of class1 slot2 draw
      step();
      bus.class_count = {3'd2, 3'd3, 3'd1};
      tick_pulse();
      n = 0;
      while (!(bus.enable_draw_obj[1] && bus.obj_index == 3'd2) && n < 40) begin
         step();
         n++;
      end
      chk("mid_obj_reached", {bus.enable_draw_obj, bus.obj_index}, {3'b010, 3'd2});
      resetn = 1'b0;
      #1;
      chk("mid_rst_obj", {bus.enable_draw_obj, bus.obj_index}, 0);
      chk("mid_rst_enables", {bus.enable_random, bus.enable_draw_background,
                              bus.enable_draw_hook, bus.enable_draw_num, bus.frame_done}, 0);
      chk("mid_rst_ro", bus.resetn_objects, 1);
      step();
      resetn = 1'b1;
      step();
      chk("restart_random", bus.enable_random, 1);
      chk("restart_idx", bus.obj_index, 0);
      step();
      chk("restart_bg", bus.enable_draw_background, 1);
      chk("onehot_obj", onehot_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1);
   end
endmodule
